// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the ID-stage hazard logic: mult/div counter sizing,
// default mult/div latency, the forwarding-mux select encoding and the
// load-use hazard detector used by the stall controller.
package hazard_stall_ctrl_pkg;

    localparam int MD_CNT_W       = 4;
    localparam int MD_LAT_DEFAULT = 4;

    // Select values for the ALU operand forwarding muxes (companion forwarding unit).
    typedef enum logic [1:0] {
        FWD_ID_EX  = 2'b00,   // operand from the ID/EX register file read
        FWD_MEM_WB = 2'b01,   // operand forwarded from the write-back stage
        FWD_EX_MEM = 2'b10    // operand forwarded from the EX/MEM result
    } fwd_sel_e;

    // A load in EX whose destination is a source of the ID instruction; $zero never hazards.
    function automatic logic load_use_haz(
        input logic       ex_memread,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       id_uses_rt
    );
        logic hit_s;
        hit_s = (ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt));
        return ex_memread && (ex_rt != 5'd0) && hit_s;
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_timer.sv
// Mult/div occupancy timer: loads the unit latency on a start pulse and counts
// down to zero; busy while non-zero, done in the final busy cycle.
module hazard_stall_ctrl_md_busy_timer
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MD_LAT = MD_LAT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic md_go,
    output logic md_busy,
    output logic md_done
);

    localparam logic [MD_CNT_W-1:0] LAT_VAL  = MD_CNT_W'(MD_LAT);
    localparam logic [MD_CNT_W-1:0] CNT_ZERO = {MD_CNT_W{1'b0}};
    localparam logic [MD_CNT_W-1:0] CNT_ONE  = {{(MD_CNT_W-1){1'b0}}, 1'b1};

    logic [MD_CNT_W-1:0] md_cnt_r;

    // Remaining busy cycles; reset abandons any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_cnt_r <= CNT_ZERO;
        end else if (md_go) begin
            md_cnt_r <= LAT_VAL;
        end else if (md_cnt_r != CNT_ZERO) begin
            md_cnt_r <= md_cnt_r - CNT_ONE;
        end else begin
            md_cnt_r <= md_cnt_r;
        end
    end

    assign md_busy = (md_cnt_r != CNT_ZERO);
    assign md_done = (md_cnt_r == CNT_ONE);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard/stall controller: resolves taken-branch flushes, load-use
// stalls and HI/LO occupancy stalls into PC/IF-ID enables and flush controls,
// and keeps a saturating count of stalled cycles.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MD_LAT = MD_LAT_DEFAULT,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_md_start,
    input  logic             id_reads_hilo,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_rt,
    input  logic             branch_taken,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFID_flush,
    output logic             IDEX_flush,
    output logic             md_go,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] STALL_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             load_haz_s;
    logic             md_haz_s;
    logic             pc_write_s;
    logic             ifid_write_s;
    logic             ifid_flush_s;
    logic             idex_flush_s;
    logic             md_go_s;
    logic             md_busy_s;
    logic             md_done_s;
    logic [CNT_W-1:0] stall_cnt_r;

    assign load_haz_s = load_use_haz(ex_MemRead, ex_rt, id_rs, id_rt, id_uses_rt);
    assign md_haz_s   = md_busy_s && (id_reads_hilo || id_md_start);

    // Prioritised control decode: reset, branch flush, then a single shared stall.
    always_comb begin
        pc_write_s   = 1'b1;
        ifid_write_s = 1'b1;
        ifid_flush_s = 1'b0;
        idex_flush_s = 1'b0;
        md_go_s      = 1'b0;
        if (rst) begin
            pc_write_s   = 1'b0;
            ifid_write_s = 1'b0;
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
        end else if (branch_taken) begin
            // The ID instruction is discarded, so any stall it would cause is moot.
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
        end else if (load_haz_s || md_haz_s) begin
            pc_write_s   = 1'b0;
            ifid_write_s = 1'b0;
            idex_flush_s = 1'b1;
        end else begin
            md_go_s      = id_md_start;
        end
    end

    hazard_stall_ctrl_md_busy_timer #(
        .MD_LAT (MD_LAT)
    ) u_md_busy_timer (
        .clk     (clk),
        .rst     (rst),
        .md_go   (md_go_s),
        .md_busy (md_busy_s),
        .md_done (md_done_s)
    );

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (!pc_write_s && (stall_cnt_r != STALL_MAX)) begin
            stall_cnt_r <= stall_cnt_r + STALL_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign PCWrite      = pc_write_s;
    assign IFIDWrite    = ifid_write_s;
    assign IFID_flush   = ifid_flush_s;
    assign IDEX_flush   = idex_flush_s;
    assign md_go        = md_go_s;
    assign md_busy      = md_busy_s;
    assign md_done      = md_done_s;
    assign stall_cycles = stall_cnt_r;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: a default-width instance and a 4-bit-counter
// instance share stimulus; a rule-level model is checked every negedge, and
// directed scenarios pin the model with literal expectations.
module tb_hazard_stall_ctrl;

    localparam int MD_LAT = 4;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic id_uses_rt, id_md_start, id_reads_hilo, ex_MemRead, branch_taken;

    logic PCWrite, IFIDWrite, IFID_flush, IDEX_flush, md_go, md_busy, md_done;
    logic [15:0] stall_cycles;
    logic PCWrite4, IFIDWrite4, IFID_flush4, IDEX_flush4, md_go4, md_busy4, md_done4;
    logic [3:0] stall_cycles4;

    int vectors = 0;
    int miscompares = 0;

    // model state: busy cycles left, total stalled cycles since reset
    int     m_rem = 0;
    longint m_stalls = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MD_LAT(MD_LAT), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_md_start(id_md_start), .id_reads_hilo(id_reads_hilo), .ex_MemRead(ex_MemRead),
        .ex_rt(ex_rt), .branch_taken(branch_taken), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
        .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush), .md_go(md_go), .md_busy(md_busy),
        .md_done(md_done), .stall_cycles(stall_cycles)
    );

    hazard_stall_ctrl #(.MD_LAT(MD_LAT), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_md_start(id_md_start), .id_reads_hilo(id_reads_hilo), .ex_MemRead(ex_MemRead),
        .ex_rt(ex_rt), .branch_taken(branch_taken), .PCWrite(PCWrite4), .IFIDWrite(IFIDWrite4),
        .IFID_flush(IFID_flush4), .IDEX_flush(IDEX_flush4), .md_go(md_go4), .md_busy(md_busy4),
        .md_done(md_done4), .stall_cycles(stall_cycles4)
    );

    // Expected {PCWrite, IFIDWrite, IFID_flush, IDEX_flush, md_go, md_busy, md_done}
    function automatic logic [6:0] expect_vec();
        logic busy, done, lh, mh;
        if (rst) return 7'b0011000;
        busy = (m_rem > 0);
        done = (m_rem == 1);
        lh = ex_MemRead && (ex_rt != 5'd0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        mh = busy && (id_reads_hilo || id_md_start);
        if (branch_taken) return {4'b1111, 1'b0, busy, done};
        if (lh || mh)     return {4'b0001, 1'b0, busy, done};
        return {4'b1100, id_md_start, busy, done};
    endfunction

    function automatic longint sat(input longint v, input longint maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // Model state advance on each edge (inputs are still the pre-edge values).
    always @(posedge clk or posedge rst) begin
        logic [6:0] v;
        if (rst) begin
            m_rem = 0;
            m_stalls = 0;
        end else begin
            v = expect_vec();
            if (v[2]) m_rem = MD_LAT;
            else if (m_rem > 0) m_rem = m_rem - 1;
            if (!v[6]) m_stalls = m_stalls + 1;
        end
    end

    // Compare both instances against the model every cycle.
    always @(negedge clk) begin
        logic [6:0] e, a, a4;
        longint e16, e4;
        e   = expect_vec();
        a   = {PCWrite, IFIDWrite, IFID_flush, IDEX_flush, md_go, md_busy, md_done};
        a4  = {PCWrite4, IFIDWrite4, IFID_flush4, IDEX_flush4, md_go4, md_busy4, md_done4};
        e16 = sat(m_stalls, 65535);
        e4  = sat(m_stalls, 15);
        vectors++;
        if (a !== e || a4 !== e || longint'(stall_cycles) != e16 || longint'(stall_cycles4) != e4) begin
            miscompares++;
            $display("FAIL model t=%0t ctrl=%b ctrl4=%b exp=%b stall=%0d exp=%0d stall4=%0d exp=%0d",
                     $time, a, a4, e, stall_cycles, e16, stall_cycles4, e4);
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic to_neg();
        @(negedge clk); #1;
    endtask

    task automatic to_next();
        @(posedge clk); #1;
    endtask

    task automatic clr_in();
        id_rs = 5'd1; id_rt = 5'd2; ex_rt = 5'd3;
        id_uses_rt = 1'b0; id_md_start = 1'b0; id_reads_hilo = 1'b0;
        ex_MemRead = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        to_neg();
        to_next();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clr_in();
        to_neg();
        check("rst_stall", stall_cycles, 0);
        check("rst_pcwrite", PCWrite, 0);
        check("rst_ifid_flush", IFID_flush, 1);
        check("rst_idex_flush", IDEX_flush, 1);
        to_next();
        rst = 1'b0;

        // load-use stall then release
        ex_MemRead = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        to_neg();
        check("lu_pcwrite", PCWrite, 0);
        check("lu_ifidwrite", IFIDWrite, 0);
        check("lu_idex_flush", IDEX_flush, 1);
        to_next();
        clr_in();
        to_neg();
        check("lu_release", PCWrite, 1);
        check("lu_stall_cnt", stall_cycles, 1);
        to_next();

        // $zero and unused rt never stall
        ex_MemRead = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        to_neg();
        check("r0_nostall", PCWrite, 1);
        to_next();
        ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd1; id_uses_rt = 1'b0;
        to_neg();
        check("rt_unused_nostall", PCWrite, 1);
        to_next();
        clr_in();

        // mult/div occupancy timing
        do_reset();
        id_md_start = 1'b1;
        to_neg();
        check("md_go", md_go, 1);
        to_next();
        id_md_start = 1'b0; id_reads_hilo = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            to_neg();
            check("md_stall", PCWrite, 0);
            check("md_done", md_done, (c == 4) ? 1 : 0);
            to_next();
        end
        to_neg();
        check("md_release", PCWrite, 1);
        check("md_stall_cnt", stall_cycles, 4);
        to_next();
        clr_in();

        // branch beats load-use, and suppresses md_go
        branch_taken = 1'b1; ex_MemRead = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        to_neg();
        check("br_pcwrite", PCWrite, 1);
        check("br_ifid_flush", IFID_flush, 1);
        check("br_idex_flush", IDEX_flush, 1);
        to_next();
        clr_in();
        branch_taken = 1'b1; id_md_start = 1'b1;
        to_neg();
        check("br_md_go", md_go, 0);
        to_next();
        clr_in();
        to_neg();
        check("br_md_busy", md_busy, 0);
        to_next();

        // reset while busy with md_cnt=2
        do_reset();
        id_md_start = 1'b1;
        to_next();
        id_md_start = 1'b0; id_reads_hilo = 1'b1;
        to_next();
        to_next();
        check("pre_rst_busy", md_busy, 1);
        check("pre_rst_stall", stall_cycles, 2);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", md_busy, 0);
        check("mid_rst_stall", stall_cycles, 0);
        check("mid_rst_pcwrite", PCWrite, 0);
        check("mid_rst_ifid_flush", IFID_flush, 1);
        to_next();
        id_md_start = 1'b1; id_reads_hilo = 1'b0;
        to_neg();
        check("rst_hold_md_go", md_go, 0);
        check("rst_hold_ifidwrite", IFIDWrite, 0);
        to_next();
        rst = 1'b0;
        clr_in();

        // saturation of the 4-bit counter
        do_reset();
        ex_MemRead = 1'b1; ex_rt = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b1;
        repeat (20) to_next();
        clr_in();
        to_neg();
        check("sat4", stall_cycles4, 15);
        check("sat16", stall_cycles, 20);
        to_next();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) rst = 1'b1;
            else if (rst && $urandom_range(0, 1) == 0) rst = 1'b0;
            id_rs         = 5'($urandom_range(0, 3));
            id_rt         = 5'($urandom_range(0, 3));
            ex_rt         = 5'($urandom_range(0, 3));
            id_uses_rt    = 1'($urandom_range(0, 1));
            ex_MemRead    = ($urandom_range(0, 3) == 0);
            id_md_start   = ($urandom_range(0, 3) == 0);
            id_reads_hilo = ($urandom_range(0, 3) == 0);
            branch_taken  = ($urandom_range(0, 7) == 0);
            to_next();
        end
        rst = 1'b0;
        clr_in();
        to_next();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline hazard/stall controller for the 5-stage MIPS pipeline; sits in ID beside the forwarding unit.
- Covers what forwarding cannot: load-use stalls, multi-cycle mult/div occupancy of HI/LO, and taken-branch flushes.
- Drives PC/IF-ID write enables and IF/ID, ID/EX flush (bubble) controls.
- Tracks mult/div busy cycles and a saturating stall-cycle performance counter.

Parameters:
- MD_LAT, 4, cycles the mult/div unit is busy after an accepted start (legal range 1..15).
- CNT_W, 16, width of the stall_cycles counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- id_rs  input  5  rs field of the instruction in ID.
- id_rt  input  5  rt field of the instruction in ID.
- id_uses_rt  input  1  ID instruction reads rt as a source.
- id_md_start  input  1  ID instruction is mult/multu/div/divu.
- id_reads_hilo  input  1  ID instruction is mfhi/mflo.
- ex_MemRead  input  1  EX-stage instruction is a load.
- ex_rt  input  5  destination register of the EX-stage load.
- branch_taken  input  1  branch/jump resolved taken in EX this cycle.
- PCWrite  output  1  PC update enable.
- IFIDWrite  output  1  IF/ID register write enable.
- IFID_flush  output  1  zero the IF/ID register next edge.
- IDEX_flush  output  1  insert a bubble into ID/EX next edge.
- md_go  output  1  start pulse to the mult/div unit.
- md_busy  output  1  mult/div unit occupied.
- md_done  output  1  one-cycle pulse in the last busy cycle.
- stall_cycles  output  CNT_W  saturating count of cycles with PCWrite=0.

Behaviour:
- Reset (async, rst=1): md_cnt=0 and stall_cycles=0 immediately. While rst is high, outputs are PCWrite=0, IFIDWrite=0, IFID_flush=1, IDEX_flush=1, md_go=0, md_busy=0, md_done=0.
- Control outputs are combinational from inputs plus registered state. md_cnt and stall_cycles update on the rising clk edge.
- load_haz = ex_MemRead && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
- md_haz = md_busy && (id_reads_hilo || id_md_start).
- Priority, highest first:
  1. branch_taken: PCWrite=1, IFIDWrite=1, IFID_flush=1, IDEX_flush=1, md_go=0. Stalls are overridden because the ID instruction is discarded.
  2. load_haz: PCWrite=0, IFIDWrite=0, IDEX_flush=1, IFID_flush=0, md_go=0.
  3. md_haz: same outputs as load_haz; the stall holds until md_busy drops.
  4. Otherwise: PCWrite=1, IFIDWrite=1, flushes=0, md_go=id_md_start.
- md_cnt is 4 bits, md_busy = (md_cnt!=0).
  - On md_go: md_cnt loads MD_LAT.
  - Else if md_cnt!=0: md_cnt decrements.
  - md_go cannot coincide with md_busy=1, because md_haz blocks it.
- md_done = (md_cnt==1).
- Timing example, MD_LAT=4: md_go in cycle 0; md_busy in cycles 1-4; md_done in cycle 4; a dependent mfhi waiting in ID is released in cycle 5.
- branch_taken while md_busy: md_cnt continues counting. The mult/div instruction is older than the branch and must complete.
- stall_cycles increments on every edge where rst=0 and PCWrite=0, and saturates at all-ones.
- Simultaneous load_haz and md_haz: a single stall; the hazards are not counted twice.
- Register 0 never causes a load-use stall.
- rst asserted mid-operation: md_cnt clears immediately and any in-flight mult/div is abandoned.

Decomposition:
- Shared package holds MD_CNT_W=4, the default MD_LAT, and the encoding of the Forward* select values used by the companion forwarding logic.
- One natural sub-module, md_busy_timer: it encapsulates md_cnt, md_busy and md_done.

Test Plan:
- Load-use: ex_MemRead=1, ex_rt=8, id_rs=8 -> that cycle PCWrite=0, IFIDWrite=0, IDEX_flush=1; next cycle (ex_MemRead=0) PCWrite=1; stall_cycles=1.
- ex_rt=0 with id_rs=0 and ex_MemRead=1 -> no stall. id_uses_rt=0 with ex_rt=id_rt=9 -> no stall.
- Mult/div timing: id_md_start=1 in cycle 0 gives md_go=1. Then id_reads_hilo=1 from cycle 1 -> PCWrite=0 in cycles 1-4, md_done=1 in cycle 4, PCWrite=1 in cycle 5, stall_cycles=4.
- Branch priority: branch_taken=1 together with load_haz=1 -> PCWrite=1, IFID_flush=1, IDEX_flush=1. With id_md_start=1 instead -> md_go=0.
- Reset mid-operation: assert rst during md_busy (md_cnt=2) -> md_busy=0 and stall_cycles=0 immediately; outputs hold reset values until rst deasserts.
- Saturation: CNT_W=4, hold a stall for 20 cycles -> stall_cycles stops at 15.
